// File: rtl/apb_i2c_cmd_bridge.sv
// APB3 register front-end that launches single-byte I2C master transactions.
// Ports: APB slave (psel..pslverr), master command/result (wdata..i2c_ready_busyBar), irq.
module apb_i2c_cmd_bridge #(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 7,
  parameter int ACK_TIMEOUT = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [7:0]            paddr,
  input  logic [31:0]           pwdata,
  output logic [31:0]           prdata,
  output logic                  pready,
  output logic                  pslverr,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic [ADDR_WIDTH-1:0] i2c_target_addr,
  output logic                  i2cwr_rdBar,
  output logic                  apb_data_valid,
  output logic                  req,
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic                  i2c_data_valid,
  input  logic                  i2c_ready_busyBar,
  output logic                  irq
);

  localparam int CW = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_RDY,
    S_ISSUE,
    S_WAIT_BUSY,
    S_WAIT_DONE
  } state_t;

  state_t                state;
  logic [CW-1:0]         cnt;
  logic                  got_byte;

  logic [DATA_WIDTH-1:0] tx_data;
  logic [ADDR_WIDTH-1:0] taddr;
  logic                  wr_rd;
  logic                  irq_en;
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_valid;
  logic                  done;
  logic                  err_ovr;
  logic                  err_to;

  logic acc, wr_en, rd_en;
  logic sel_tx, sel_ta, sel_ctrl, sel_stat, sel_rx, mapped;
  logic busy, start_req, go;
  logic [3:0] w1c;
  logic rx_rd, cap, done_ev, to_ev, ovr_ev;
  logic unused_pwdata;

  assign acc      = psel & penable;
  assign wr_en    = acc & pwrite;
  assign rd_en    = acc & ~pwrite;
  assign sel_tx   = paddr == 8'h00;
  assign sel_ta   = paddr == 8'h04;
  assign sel_ctrl = paddr == 8'h08;
  assign sel_stat = paddr == 8'h0C;
  assign sel_rx   = paddr == 8'h10;
  assign mapped   = sel_tx | sel_ta | sel_ctrl
                  | sel_stat | sel_rx;

  assign pready  = 1'b1;
  assign pslverr = acc & ~mapped;
  assign irq     = done & irq_en;

  assign busy      = state != S_IDLE;
  assign start_req = wr_en & sel_ctrl & pwdata[0];
  assign go        = start_req & ~busy;
  assign ovr_ev    = start_req & busy;
  assign w1c       = (wr_en & sel_stat) ? pwdata[4:1] : 4'b0;
  assign rx_rd     = rd_en & sel_rx;

  // Direction comes from the shadow copy so mid-flight CTRL writes
  // cannot change how the running transaction completes.
  assign cap     = (state == S_WAIT_DONE) & ~i2cwr_rdBar
                 & i2c_data_valid;
  assign done_ev = (state == S_WAIT_DONE) & i2c_ready_busyBar
                 & (i2cwr_rdBar | got_byte | cap);
  assign to_ev   = (state == S_WAIT_BUSY) & i2c_ready_busyBar
                 & (cnt == CW'(ACK_TIMEOUT - 1));

  assign unused_pwdata = ^pwdata;

  always_comb begin
    prdata = '0;
    if (rd_en) begin
      unique case (1'b1)
        sel_tx:   prdata = 32'(tx_data);
        sel_ta:   prdata = 32'(taddr);
        sel_ctrl: prdata = {29'b0, irq_en, wr_rd, 1'b0};
        sel_stat: prdata = {27'b0, err_to, err_ovr,
                            done, rx_valid, busy};
        sel_rx:   prdata = 32'(rx_data);
        default:  prdata = '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_data <= '0;
      taddr   <= '0;
      wr_rd   <= 1'b0;
      irq_en  <= 1'b0;
    end else if (wr_en) begin
      if (sel_tx)   tx_data <= pwdata[DATA_WIDTH-1:0];
      if (sel_ta)   taddr   <= pwdata[ADDR_WIDTH-1:0];
      if (sel_ctrl) begin
        wr_rd  <= pwdata[1];
        irq_en <= pwdata[2];
      end
    end
  end

  // Hardware sets win over a same-cycle W1C or RXDATA read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_data  <= '0;
      rx_valid <= 1'b0;
      done     <= 1'b0;
      err_ovr  <= 1'b0;
      err_to   <= 1'b0;
    end else begin
      if (cap) rx_data <= rdata;
      rx_valid <= cap | (rx_valid & ~w1c[0] & ~rx_rd);
      done     <= done_ev | (done & ~w1c[1]);
      err_ovr  <= ovr_ev | (err_ovr & ~w1c[2]);
      err_to   <= to_ev | (err_to & ~w1c[3]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= S_IDLE;
      cnt             <= '0;
      got_byte        <= 1'b0;
      wdata           <= '0;
      i2c_target_addr <= '0;
      i2cwr_rdBar     <= 1'b0;
      apb_data_valid  <= 1'b0;
      req             <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (go) state <= S_WAIT_RDY;
        end
        S_WAIT_RDY: begin
          if (i2c_ready_busyBar) begin
            state           <= S_ISSUE;
            wdata           <= tx_data;
            i2c_target_addr <= taddr;
            i2cwr_rdBar     <= wr_rd;
            apb_data_valid  <= 1'b1;
            req             <= 1'b1;
          end
        end
        S_ISSUE: begin
          state          <= S_WAIT_BUSY;
          apb_data_valid <= 1'b0;
          cnt            <= '0;
          got_byte       <= 1'b0;
        end
        S_WAIT_BUSY: begin
          if (!i2c_ready_busyBar) begin
            state <= S_WAIT_DONE;
          end else if (to_ev) begin
            state <= S_IDLE;
            req   <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_WAIT_DONE: begin
          if (cap) got_byte <= 1'b1;
          if (done_ev) begin
            state <= S_IDLE;
            req   <= 1'b0;
          end
        end
        default: begin
          state <= S_IDLE;
          req   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_i2c_cmd_bridge.sv
// Directed self-checking bench for apb_i2c_cmd_bridge.
// Drives APB and a scripted I2C master; checks registers and handshake.
module tb_apb_i2c_cmd_bridge;

  logic        clk;
  logic        reset;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [7:0]  paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;
  logic [7:0]  wdata;
  logic [6:0]  i2c_target_addr;
  logic        i2cwr_rdBar;
  logic        apb_data_valid;
  logic        req;
  logic [7:0]  rdata;
  logic        i2c_data_valid;
  logic        i2c_ready_busyBar;
  logic        irq;

  int n_chk;
  int n_err;
  int vcnt;

  apb_i2c_cmd_bridge dut (
    .clk               (clk),
    .reset             (reset),
    .psel              (psel),
    .penable           (penable),
    .pwrite            (pwrite),
    .paddr             (paddr),
    .pwdata            (pwdata),
    .prdata            (prdata),
    .pready            (pready),
    .pslverr           (pslverr),
    .wdata             (wdata),
    .i2c_target_addr   (i2c_target_addr),
    .i2cwr_rdBar       (i2cwr_rdBar),
    .apb_data_valid    (apb_data_valid),
    .req               (req),
    .rdata             (rdata),
    .i2c_data_valid    (i2c_data_valid),
    .i2c_ready_busyBar (i2c_ready_busyBar),
    .irq               (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk)
    if (apb_data_valid) vcnt++;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h",
               tag, got, exp);
    end
  endtask

  task automatic apb_write(input logic [7:0] a,
                           input logic [31:0] d,
                           output logic e);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1;
    paddr = a; pwdata = d;
    @(posedge clk); #1;
    penable = 1'b1;
    #3 e = pslverr;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [7:0] a,
                          output logic [31:0] d,
                          output logic e);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0;
    paddr = a;
    @(posedge clk); #1;
    penable = 1'b1;
    #3;
    d = prdata;
    e = pslverr;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic wait_valid(input string tag, output int lat);
    bit found;
    found = 1'b0;
    lat = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      lat = i + 1;
      if (apb_data_valid) found = 1'b1;
    end
    check({tag, "_valid_seen"}, 32'(found), 32'd1);
  endtask

  task automatic wait_req_low(input string tag,
                              input int budget,
                              output int n);
    bit low;
    low = 1'b0;
    n = 0;
    for (int i = 0; i < budget && !low; i++) begin
      @(negedge clk);
      if (!req) low = 1'b1;
      else n++;
    end
    check({tag, "_req_drop"}, 32'(low), 32'd1);
  endtask

  logic [31:0] d;
  logic        e;
  int          lat;
  int          n;

  initial begin
    n_chk = 0; n_err = 0; vcnt = 0;
    reset = 1'b1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0;
    rdata = '0; i2c_data_valid = 1'b0;
    i2c_ready_busyBar = 1'b1;

    repeat (3) @(negedge clk);
    check("rst_prdata", prdata, 32'h0);
    check("rst_pslverr", 32'(pslverr), 32'h0);
    check("rst_pready", 32'(pready), 32'h1);
    check("rst_valid", 32'(apb_data_valid), 32'h0);
    check("rst_req", 32'(req), 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    check("rst_shadow",
          {16'b0, wdata, i2cwr_rdBar, i2c_target_addr},
          32'h0);
    reset = 1'b0;

    apb_read(8'h0C, d, e);
    check("rst_status", d, 32'h0);

    // Write transaction.
    apb_write(8'h00, 32'hA5, e);
    apb_write(8'h04, 32'h50, e);
    vcnt = 0;
    apb_write(8'h08, 32'h3, e);
    wait_valid("wr", lat);
    check("wr_latency", 32'(lat), 32'd2);
    check("wr_wdata", 32'(wdata), 32'hA5);
    check("wr_taddr", 32'(i2c_target_addr), 32'h50);
    check("wr_dir", 32'(i2cwr_rdBar), 32'h1);
    check("wr_req", 32'(req), 32'h1);
    i2c_ready_busyBar = 1'b0;
    apb_write(8'h00, 32'h11, e);
    check("wr_shadow_hold", 32'(wdata), 32'hA5);
    apb_read(8'h0C, d, e);
    check("wr_busy", d, 32'h1);
    repeat (14) @(negedge clk);
    i2c_ready_busyBar = 1'b1;
    wait_req_low("wr", 10, n);
    check("wr_pulses", 32'(vcnt), 32'd1);
    apb_read(8'h0C, d, e);
    check("wr_status", d, 32'h4);
    apb_write(8'h0C, 32'h4, e);

    // Read transaction.
    apb_write(8'h08, 32'h1, e);
    wait_valid("rd", lat);
    check("rd_dir", 32'(i2cwr_rdBar), 32'h0);
    i2c_ready_busyBar = 1'b0;
    repeat (3) @(negedge clk);
    rdata = 8'h3C;
    i2c_data_valid = 1'b1;
    @(negedge clk);
    i2c_data_valid = 1'b0;
    rdata = 8'h00;
    i2c_ready_busyBar = 1'b1;
    wait_req_low("rd", 10, n);
    apb_read(8'h0C, d, e);
    check("rd_status", d, 32'h6);
    check("rd_irq", 32'(irq), 32'h0);
    apb_read(8'h10, d, e);
    check("rd_rxdata", d, 32'h3C);
    apb_read(8'h0C, d, e);
    check("rd_status_clr", d, 32'h4);
    apb_write(8'h0C, 32'h4, e);

    // Interrupt.
    apb_write(8'h08, 32'h7, e);
    wait_valid("irq", lat);
    i2c_ready_busyBar = 1'b0;
    repeat (4) @(negedge clk);
    i2c_ready_busyBar = 1'b1;
    wait_req_low("irq", 10, n);
    check("irq_set", 32'(irq), 32'h1);
    apb_write(8'h0C, 32'h4, e);
    check("irq_clr", 32'(irq), 32'h0);

    // Overrun.
    i2c_ready_busyBar = 1'b0;
    vcnt = 0;
    apb_write(8'h08, 32'h3, e);
    repeat (2) @(negedge clk);
    apb_write(8'h08, 32'h3, e);
    check("ovr_no_pulse", 32'(vcnt), 32'd0);
    i2c_ready_busyBar = 1'b1;
    wait_valid("ovr", lat);
    i2c_ready_busyBar = 1'b0;
    repeat (4) @(negedge clk);
    i2c_ready_busyBar = 1'b1;
    wait_req_low("ovr", 10, n);
    repeat (3) @(negedge clk);
    check("ovr_pulses", 32'(vcnt), 32'd1);
    apb_read(8'h0C, d, e);
    check("ovr_status", d, 32'hC);
    apb_write(8'h0C, 32'h8, e);
    apb_read(8'h0C, d, e);
    check("ovr_w1c", d, 32'h4);
    apb_write(8'h0C, 32'h4, e);

    // Timeout: master never goes busy.
    apb_write(8'h08, 32'h3, e);
    wait_valid("to", lat);
    wait_req_low("to", 1100, n);
    check("to_cycles", 32'(n), 32'd1024);
    apb_read(8'h0C, d, e);
    check("to_status", d, 32'h10);
    apb_write(8'h0C, 32'h10, e);

    // Unmapped address.
    apb_read(8'h20, d, e);
    check("bad_rd_err", 32'(e), 32'h1);
    check("bad_rd_data", d, 32'h0);
    apb_write(8'h20, 32'hFF, e);
    check("bad_wr_err", 32'(e), 32'h1);
    apb_read(8'h00, d, e);
    check("txdata_keep", d, 32'h11);
    check("good_err", 32'(e), 32'h0);
    apb_read(8'h0C, d, e);
    check("status_idle", d, 32'h0);

    // Reset during WAIT_DONE.
    apb_write(8'h08, 32'h7, e);
    wait_valid("mrst", lat);
    i2c_ready_busyBar = 1'b0;
    repeat (3) @(negedge clk);
    check("mrst_req_pre", 32'(req), 32'h1);
    check("mrst_wdata_pre", 32'(wdata), 32'h11);
    #1 reset = 1'b1;
    #1;
    check("mrst_req", 32'(req), 32'h0);
    check("mrst_valid", 32'(apb_data_valid), 32'h0);
    check("mrst_shadow",
          {16'b0, wdata, i2cwr_rdBar, i2c_target_addr},
          32'h0);
    check("mrst_irq", 32'(irq), 32'h0);
    i2c_ready_busyBar = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    apb_read(8'h0C, d, e);
    check("mrst_status", d, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/apb_i2c_cmd_bridge.md
Name: apb_i2c_cmd_bridge

Overview:
- APB3 slave register front-end sitting directly upstream of the single-byte I2C master actuator.
- Holds software-programmed TX data, target address and direction, then launches one I2C transaction via the master's valid/req handshake.
- Tracks completion, captures read data and exposes status and interrupt to the APB host.

Parameters:
DATA_WIDTH, 8, I2C data byte width (matches the master's `DATA_WIDTH).
ADDR_WIDTH, 7, I2C target address width (matches the master's `ADDR_WIDTH).
ACK_TIMEOUT, 1024, cycles allowed for the master to go busy after issue.

Ports:
clk  in  1  system clock, all logic rising-edge.
reset  in  1  asynchronous, active-high reset.
psel  in  1  APB select.
penable  in  1  APB enable (access phase).
pwrite  in  1  APB write=1, read=0.
paddr  in  8  APB byte address.
pwdata  in  32  APB write data.
prdata  out  32  APB read data.
pready  out  1  APB ready, tied 1 (zero wait states).
pslverr  out  1  APB error, asserted in access phase for unmapped paddr.
wdata  out  DATA_WIDTH  byte to the master.
i2c_target_addr  out  ADDR_WIDTH  target address to the master.
i2cwr_rdBar  out  1  direction to the master: 1=write, 0=read.
apb_data_valid  out  1  one-cycle launch strobe to the master.
req  out  1  device select, high from ISSUE until return to IDLE.
rdata  in  DATA_WIDTH  read byte from the master.
i2c_data_valid  in  1  master read-data valid pulse.
i2c_ready_busyBar  in  1  master ready=1 / busy=0.
irq  out  1  level interrupt = STATUS.DONE & CTRL.IRQ_EN.

Behaviour:
- Reset: all registers 0, FSM=IDLE. Outputs prdata=0, pslverr=0, apb_data_valid=0, req=0, irq=0, wdata=0, i2c_target_addr=0, i2cwr_rdBar=0. pready=1 always.
- APB access: writes commit when psel&penable&pwrite; read data is driven combinationally in the access phase.
- Register map:
  - 0x00 TXDATA RW [DATA_WIDTH-1:0].
  - 0x04 TADDR RW [ADDR_WIDTH-1:0].
  - 0x08 CTRL: bit0 START (write-only, self-clearing, reads 0); bit1 WR_RDBAR RW; bit2 IRQ_EN RW.
  - 0x0C STATUS: bit0 BUSY (RO, FSM!=IDLE or start pending); bits1-4 are W1C: bit1 RX_VALID, bit2 DONE, bit3 ERR_OVERRUN, bit4 ERR_TIMEOUT.
  - 0x10 RXDATA RO; an APB read clears RX_VALID.
  - Other addresses: pslverr=1, prdata=0, no state change.
- wdata, i2c_target_addr and i2cwr_rdBar are shadow copies of TXDATA, TADDR and WR_RDBAR, latched on entering ISSUE. They stay stable until IDLE; software register writes mid-transaction do not disturb them.
- START write while BUSY: command ignored, ERR_OVERRUN set.
- FSM:
  - IDLE: on START write (BUSY=0), go to WAIT_RDY.
  - WAIT_RDY: when i2c_ready_busyBar=1, go to ISSUE.
  - ISSUE (1 cycle): apb_data_valid=1, req=1, timeout counter cleared, go to WAIT_BUSY.
  - WAIT_BUSY: when i2c_ready_busyBar=0, go to WAIT_DONE. If the counter reaches ACK_TIMEOUT-1 first, set ERR_TIMEOUT and go to IDLE (DONE not set).
  - WAIT_DONE:
    - Read: i2c_data_valid=1 captures rdata into RXDATA and sets RX_VALID; completion when i2c_ready_busyBar=1 with the byte captured.
    - Write: completion on i2c_ready_busyBar returning to 1.
    - On completion: set DONE, go to IDLE, drop req.
- i2c_data_valid outside a read in WAIT_DONE is ignored.
- Simultaneous events:
  - Hardware sets take priority over same-cycle W1C of the same bit.
  - An RXDATA read in the same cycle as a capture returns the old data; RX_VALID stays 1.
- Minimum START-to-apb_data_valid latency is 2 cycles (IDLE, WAIT_RDY→ISSUE) when the master is ready.
- Reset mid-transaction: immediate return to IDLE; req and apb_data_valid drop asynchronously.

Test Plan:
- Write TXDATA=0xA5, TADDR=0x50, CTRL=0x3 with master ready → apb_data_valid single pulse; outputs wdata=0xA5, i2c_target_addr=0x50, i2cwr_rdBar=1. Master busy 20 cycles then ready → STATUS=0x4.
- Read command (CTRL=0x1, IRQ_EN=0), master returns rdata=0x3C with i2c_data_valid → RXDATA=0x3C, STATUS=0x6, irq=0. Reading RXDATA → STATUS bit1=0.
- Set IRQ_EN and complete a write → irq=1. Write STATUS=0x4 → irq=0 next cycle.
- START while BUSY → no second apb_data_valid; ERR_OVERRUN=1. Cleared by writing 0x8.
- Master never drops ready after ISSUE → after 1024 cycles ERR_TIMEOUT=1, req=0, BUSY=0, DONE=0.
- Access paddr=0x20 → pslverr=1, prdata=0. Assert reset in WAIT_DONE → all outputs 0 immediately.
